// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, D_BUSY, I_BUSY)
//   CNT_W       : width of the latency counter
//   PERF_W      : width of the optional performance counters
//   sat_inc     : saturating increment used by the performance counters
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_BUSY = 2'd1,
      I_BUSY = 2'd2
   } arb_state_t;

   localparam int CNT_W  = 4;
   localparam int PERF_W = 16;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
// Latency counter for one memory transaction.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : forces the count back to zero (held while the arbiter is idle)
//   run   : count one cycle of an active transaction
//   done  : high in the last bus cycle (count == MEM_LATENCY-1 while running)
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_reg <= '0;
      end else if (run) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign done = run && (cnt_reg == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single-ported 16-bit memory between instruction fetch (i_*) and
// load/store (d_*). One transaction at a time, data has priority, each
// transaction holds the bus for MEM_LATENCY cycles (legal 1..15).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   i_req/i_addr                      : fetch request (level) and address
//   i_valid/i_data/i_stall            : fetch completion pulse, data, stall
//   d_req/d_wr/d_addr/d_wdata         : load/store request and payload
//   d_valid/d_rdata/d_stall           : data completion pulse, load data, stall
//   mem_enable/mem_wr/mem_addr/mem_wdata/mem_rdata : memory bus
// Optional feature, macro MEM_ARB_PERF_CNT_EN: adds saturating 16-bit
//   perf_i_stall, perf_d_stall, perf_conflict counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_valid,
   output logic [15:0] i_data,
   output logic        i_stall,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_valid,
   output logic [15:0] d_rdata,
   output logic        d_stall,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_i_stall,
   output logic [PERF_W-1:0] perf_d_stall,
   output logic [PERF_W-1:0] perf_conflict
`endif
);

   arb_state_t  state_reg, state_next;
   logic        d_take, i_take, done;
   logic        i_valid_reg, d_valid_reg;
   logic [15:0] i_data_reg, d_rdata_reg;
   logic        mem_enable_reg, mem_wr_reg;
   logic [15:0] mem_addr_reg, mem_wdata_reg;

   // A port's request is masked in its own valid cycle: the requester has
   // not yet had a chance to drop or change it.
   logic i_req_eff, d_req_eff;
   assign i_req_eff = i_req && !i_valid_reg;
   assign d_req_eff = d_req && !d_valid_reg;

   mem_arb_timer #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(state_reg == IDLE),
      .run  (state_reg != IDLE),
      .done (done)
   );

   always_comb begin
      state_next = state_reg;
      d_take     = 1'b0;
      i_take     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (d_req_eff) begin
               d_take     = 1'b1;
               state_next = D_BUSY;
            end else if (i_req_eff) begin
               i_take     = 1'b1;
               state_next = I_BUSY;
            end
         end
         D_BUSY, I_BUSY: begin
            if (done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The mem_* registers double as the transaction latches: they are loaded
   // at accept and left alone while busy, so requester changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         i_valid_reg    <= 1'b0;
         d_valid_reg    <= 1'b0;
         i_data_reg     <= '0;
         d_rdata_reg    <= '0;
         mem_enable_reg <= 1'b0;
         mem_wr_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         i_valid_reg <= 1'b0;
         d_valid_reg <= 1'b0;
         if (d_take) begin
            mem_enable_reg <= 1'b1;
            mem_wr_reg     <= d_wr;
            mem_addr_reg   <= d_addr;
            mem_wdata_reg  <= d_wdata;
         end else if (i_take) begin
            mem_enable_reg <= 1'b1;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= i_addr;
         end
         if (done) begin
            mem_enable_reg <= 1'b0;
            mem_wr_reg     <= 1'b0;
            if (state_reg == D_BUSY) begin
               // Data transactions always complete, even if d_req dropped.
               d_valid_reg <= 1'b1;
               if (!mem_wr_reg) d_rdata_reg <= mem_rdata;
            end else if (i_req && (i_addr == mem_addr_reg)) begin
               // A fetch whose address moved away (redirect) is discarded.
               i_valid_reg <= 1'b1;
               i_data_reg  <= mem_rdata;
            end
         end
      end
   end

   assign i_valid    = i_valid_reg;
   assign i_data     = i_data_reg;
   assign d_valid    = d_valid_reg;
   assign d_rdata    = d_rdata_reg;
   assign mem_enable = mem_enable_reg;
   assign mem_wr     = mem_wr_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign i_stall    = i_req && !i_valid_reg;
   assign d_stall    = d_req && !d_valid_reg;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [PERF_W-1:0] perf_i_stall_reg, perf_d_stall_reg, perf_conflict_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_stall_reg  <= '0;
         perf_d_stall_reg  <= '0;
         perf_conflict_reg <= '0;
      end else begin
         if (i_stall) perf_i_stall_reg <= sat_inc(perf_i_stall_reg);
         if (d_stall) perf_d_stall_reg <= sat_inc(perf_d_stall_reg);
         // A conflict is an arbitration decision with both live requests;
         // a request masked by its own valid pulse does not compete.
         if (state_reg == IDLE && i_req_eff && d_req_eff)
            perf_conflict_reg <= sat_inc(perf_conflict_reg);
      end
   end

   assign perf_i_stall  = perf_i_stall_reg;
   assign perf_d_stall  = perf_d_stall_reg;
   assign perf_conflict = perf_conflict_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed test of mem_arbiter with MEM_LATENCY=4: reset state, single fetch,
// data/fetch conflict, store, fetch redirect, reset mid-transaction, and the
// optional performance counters when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_valid, i_stall, d_valid, d_stall, mem_enable, mem_wr;
   logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [15:0] perf_i_stall, perf_d_stall, perf_conflict;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LATENCY(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_stall   (i_stall),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .d_stall   (d_stall),
      .mem_enable(mem_enable),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .perf_i_stall (perf_i_stall),
      .perf_d_stall (perf_d_stall),
      .perf_conflict(perf_conflict)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge: the start of a new cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 16'hDEAD;

      // ---------------- reset state
      do_reset();
      check("rst_i_valid", i_valid, 0);
      check("rst_d_valid", d_valid, 0);
      check("rst_i_data", i_data, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_mem_enable", mem_enable, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      $display("txn reset done");

      // ---------------- single fetch of 0x0010
      next_cycle();
      i_req = 1'b1; i_addr = 16'h0010; #1;
      check("t1_c0_i_stall", i_stall, 1);
      check("t1_c0_mem_enable", mem_enable, 0);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         mem_rdata = (c == 4) ? 16'hA5A5 : 16'hDEAD; #1;
         check($sformatf("t1_c%0d_mem_enable", c), mem_enable, 1);
         check($sformatf("t1_c%0d_mem_addr", c), mem_addr, 16'h0010);
         check($sformatf("t1_c%0d_mem_wr", c), mem_wr, 0);
         check($sformatf("t1_c%0d_i_valid", c), i_valid, 0);
         check($sformatf("t1_c%0d_i_stall", c), i_stall, 1);
      end
      next_cycle(); #1;
      check("t1_c5_i_valid", i_valid, 1);
      check("t1_c5_i_data", i_data, 16'hA5A5);
      check("t1_c5_i_stall", i_stall, 0);
      check("t1_c5_mem_enable", mem_enable, 0);
      next_cycle();
      i_req = 1'b0; #1;
      check("t1_c6_i_valid", i_valid, 0);
      check("t1_c6_mem_enable", mem_enable, 0);
      check("t1_c6_i_data_held", i_data, 16'hA5A5);
      $display("txn fetch addr=0010 data=%h", i_data);

      // ---------------- conflict: load 0x0200 and fetch 0x0020 together
      do_reset();
      next_cycle();
      i_req = 1'b1; i_addr = 16'h0020;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200; #1;
      check("t2_c0_i_stall", i_stall, 1);
      check("t2_c0_d_stall", d_stall, 1);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         mem_rdata = (c == 4) ? 16'h5A5A : 16'hDEAD; #1;
         check($sformatf("t2_c%0d_mem_enable", c), mem_enable, 1);
         check($sformatf("t2_c%0d_mem_addr", c), mem_addr, 16'h0200);
      end
      next_cycle(); #1;
      check("t2_c5_d_valid", d_valid, 1);
      check("t2_c5_d_rdata", d_rdata, 16'h5A5A);
      check("t2_c5_d_stall", d_stall, 0);
      check("t2_c5_i_valid", i_valid, 0);
      check("t2_c5_i_stall", i_stall, 1);
      check("t2_c5_mem_enable", mem_enable, 0);
      for (int c = 6; c <= 9; c++) begin
         next_cycle();
         if (c == 6) d_req = 1'b0;
         mem_rdata = (c == 9) ? 16'h1111 : 16'hDEAD; #1;
         check($sformatf("t2_c%0d_mem_enable", c), mem_enable, 1);
         check($sformatf("t2_c%0d_mem_addr", c), mem_addr, 16'h0020);
         check($sformatf("t2_c%0d_d_valid", c), d_valid, 0);
      end
      next_cycle(); #1;
      check("t2_c10_i_valid", i_valid, 1);
      check("t2_c10_i_data", i_data, 16'h1111);
      check("t2_c10_d_rdata", d_rdata, 16'h5A5A);
      next_cycle();
      i_req = 1'b0; #1;
`ifdef MEM_ARB_PERF_CNT_EN
      check("perf_conflict", perf_conflict, 1);
      check("perf_d_stall", perf_d_stall, 5);
      check("perf_i_stall", perf_i_stall, 10);
`endif
      $display("txn conflict load=%h fetch=%h", d_rdata, i_data);

      // ---------------- store 0x1234 to 0x0300
      next_cycle();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'h1234;
      mem_rdata = 16'hBEEF; #1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle(); #1;
         check($sformatf("t3_c%0d_mem_enable", c), mem_enable, 1);
         check($sformatf("t3_c%0d_mem_wr", c), mem_wr, 1);
         check($sformatf("t3_c%0d_mem_addr", c), mem_addr, 16'h0300);
         check($sformatf("t3_c%0d_mem_wdata", c), mem_wdata, 16'h1234);
      end
      next_cycle(); #1;
      check("t3_c5_d_valid", d_valid, 1);
      check("t3_c5_d_rdata_unchanged", d_rdata, 16'h5A5A);
      check("t3_c5_mem_wr", mem_wr, 0);
      next_cycle();
      d_req = 1'b0; d_wr = 1'b0; #1;
      check("t3_c6_d_valid", d_valid, 0);
      check("t3_c6_mem_enable", mem_enable, 0);
      $display("txn store addr=0300 data=1234");

      // ---------------- fetch redirect 0x0010 -> 0x0040
      next_cycle();
      i_req = 1'b1; i_addr = 16'h0010; mem_rdata = 16'hDEAD; #1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         if (c == 2) i_addr = 16'h0040;
         mem_rdata = (c == 4) ? 16'h7777 : 16'hDEAD; #1;
         check($sformatf("t4_c%0d_mem_addr", c), mem_addr, 16'h0010);
      end
      next_cycle(); #1;
      check("t4_c5_i_valid", i_valid, 0);
      check("t4_c5_i_data_unchanged", i_data, 16'h1111);
      check("t4_c5_i_stall", i_stall, 1);
      for (int c = 6; c <= 9; c++) begin
         next_cycle();
         mem_rdata = (c == 9) ? 16'h4040 : 16'hDEAD; #1;
         check($sformatf("t4_c%0d_mem_enable", c), mem_enable, 1);
         check($sformatf("t4_c%0d_mem_addr", c), mem_addr, 16'h0040);
         check($sformatf("t4_c%0d_i_valid", c), i_valid, 0);
      end
      next_cycle(); #1;
      check("t4_c10_i_valid", i_valid, 1);
      check("t4_c10_i_data", i_data, 16'h4040);
      next_cycle();
      i_req = 1'b0; #1;
      $display("txn redirect fetch addr=0040 data=%h", i_data);

      // ---------------- reset in the middle of a load
      next_cycle();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500; mem_rdata = 16'h9999; #1;
      next_cycle(); #1;
      check("t5_c1_mem_enable", mem_enable, 1);
      next_cycle();
      rst = 1'b1; #1;
      check("t5_c2_mem_enable", mem_enable, 1);
      next_cycle();
      rst = 1'b0; d_req = 1'b0; #1;
      check("t5_c3_mem_enable", mem_enable, 0);
      check("t5_c3_d_valid", d_valid, 0);
      check("t5_c3_d_rdata", d_rdata, 0);
      check("t5_c3_i_data", i_data, 0);
      check("t5_c3_mem_addr", mem_addr, 0);
      for (int c = 4; c <= 6; c++) begin
         next_cycle(); #1;
         check($sformatf("t5_c%0d_d_valid", c), d_valid, 0);
         check($sformatf("t5_c%0d_mem_enable", c), mem_enable, 0);
      end
      // Arbiter must be back in IDLE: a new fetch is accepted immediately.
      next_cycle();
      i_req = 1'b1; i_addr = 16'h0060; #1;
      next_cycle(); #1;
      check("t5_new_mem_enable", mem_enable, 1);
      check("t5_new_mem_addr", mem_addr, 16'h0060);
      i_req = 1'b0;
      $display("txn reset-abort load addr=0500");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified 16-bit memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU. Requests are accepted one at a time, with data priority, and each transaction holds the memory for a fixed latency. The block signals completion back to the requesting stage and drives per-stage stall outputs to the hazard logic.

## Interface
- MEM_LATENCY, 4: cycles the memory bus is held per transaction; legal range 1–15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request (level), held by IF until i_valid.
- i_addr  input  16  fetch address.
- i_valid  output  1  one-cycle fetch completion pulse.
- i_data  output  16  fetched instruction; held until the next fetch completion.
- i_stall  output  1  i_req & ~i_valid (combinational).
- d_req  input  1  data request (level), held by MEM until d_valid.
- d_wr  input  1  1 = store, 0 = load.
- d_addr  input  16  data address.
- d_wdata  input  16  store data.
- d_valid  output  1  one-cycle data completion pulse (loads and stores).
- d_rdata  output  16  load data; held until the next load completion.
- d_stall  output  1  d_req & ~d_valid (combinational).
- mem_enable  output  1  memory access active.
- mem_wr  output  1  memory write.
- mem_addr  output  16  memory address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data; valid in the last enabled cycle.

## Operation
- **FSM states:** IDLE, D_BUSY, I_BUSY. There is a 4-bit latency counter `cnt`.
- **Arbitration in IDLE:**
  - A port's req is ignored in the cycle its own valid is high.
  - Otherwise d_req wins over i_req.
  - On accept: latch the address (plus wr and wdata for data), go to D_BUSY or I_BUSY, clear cnt.
- **BUSY:**
  - Memory outputs are driven from the latches. Requester input changes are ignored.
  - cnt increments each cycle.
  - At cnt == MEM_LATENCY-1, capture mem_rdata, return to IDLE and pulse valid in the next cycle.
- **Loads:** update d_rdata. **Stores:** d_rdata is unchanged; mem_wr is high for every enabled cycle.
- **Fetch redirect:** at the completion edge, i_valid is raised only if i_req == 1 and i_addr equals the latched address.
  - Otherwise the result is discarded: i_data is unchanged and there is no pulse.
  - The IDLE cycle then re-arbitrates normally.
- **Data requests cannot be cancelled.** If d_req drops mid-transaction, the transaction still completes and d_valid still pulses.
- **Reset:** state IDLE, cnt 0. All outputs are 0, including i_data, d_rdata, and the mem_* outputs.
- **Reset mid-transaction:** the transaction is aborted with no valid pulse, and mem_enable is 0 after the reset edge. Commit of an interrupted store is undefined.

## Timing
- Request first seen in IDLE at cycle 0:
  - mem_enable high in cycles 1..MEM_LATENCY;
  - valid in cycle MEM_LATENCY+1.
- Minimum per-port turnaround is MEM_LATENCY+2 cycles.
- A pending fetch is accepted in a data-valid cycle, so back-to-back data requests alternate with fetches.
- All non-stall outputs are registered. Stalls are combinational from the req inputs and registered valid.

## Configuration
- **MEM_ARB_PERF_CNT_EN defined:** adds three outputs, each 16 bits, saturating, and 0 on reset:
  - perf_i_stall: counts cycles with i_stall.
  - perf_d_stall: counts cycles with d_stall.
  - perf_conflict: counts IDLE cycles in which both ports request.
- **Undefined:** these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, D_BUSY, I_BUSY);
  - the counter width constant CNT_W = 4;
  - the perf counter width.
- One sub-module, `mem_arb_timer`: the latency counter with a done output, taking load/clear and MEM_LATENCY.

## Test plan
- **Single fetch:** MEM_LATENCY=4, i_req=1, i_addr=0x0010, memory returns 0xA5A5 → mem_enable and mem_addr=0x0010 in cycles 1–4, i_valid in cycle 5 with i_data=0xA5A5, i_stall high in cycles 0–4.
- **Conflict:** i_req and d_req (load 0x0200) both raised in cycle 0 → data bus in cycles 1–4, d_valid in cycle 5; fetch accepted in cycle 5, i_valid in cycle 10.
- **Store:** d_wr=1, d_addr=0x0300, d_wdata=0x1234 → mem_wr=1 and mem_wdata=0x1234 in cycles 1–4, d_valid in cycle 5, d_rdata unchanged.
- **Redirect:** i_addr changes from 0x0010 to 0x0040 in cycle 2 → no i_valid in cycle 5; fetch of 0x0040 starts in cycle 5, i_valid in cycle 10 with its data.
- **Reset mid-transaction:** rst in cycle 2 of D_BUSY → mem_enable=0 in cycle 3, no d_valid, state IDLE, d_rdata=0.
- **Perf counters (MEM_ARB_PERF_CNT_EN):** after the conflict scenario → perf_conflict=1, perf_d_stall=5, perf_i_stall=10.
